// File: rtl/ringbuf_pass_ctrl.sv
// Pass controller for an in-order ring buffer: walks nwords elements per start,
// offers each one downstream and optionally writes the returned result back.
module ringbuf_pass_ctrl #(
    parameter int  nbits  = 8,
    parameter int  nwords = 8,
    localparam int IW     = $clog2(nwords)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             mode_wr,
    output logic             busy,
    output logic             done,
    output logic             rb_en,
    output logic             rb_wren,
    output logic [nbits-1:0] rb_d,
    input  logic [nbits-1:0] rb_q,
    output logic [nbits-1:0] out_data,
    output logic [IW-1:0]    out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [nbits-1:0] res_data,
    input  logic             res_valid
);

    generate
        if (nwords < 2) begin : g_illegal
            Illegal_parameter__nwords_must_be_at_least_2 u_illegal ();
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        WAIT_RES,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic          mode, mode_nx;
    logic          last_idx;

    assign last_idx = (idx == IW'(nwords - 1));

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= IDLE;
            idx   <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            mode  <= mode_nx;
        end
    end

    // Every rb_en pulse is one step of the ring, so a full pass of nwords steps
    // leaves the buffer in the rotation it had before start.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        mode_nx   = mode;
        busy      = (state != IDLE);
        done      = 1'b0;
        rb_en     = 1'b0;
        rb_wren   = 1'b0;
        rb_d      = '0;
        out_data  = '0;
        out_idx   = '0;
        out_valid = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    mode_nx  = mode_wr;
                    idx_nx   = '0;
                    state_nx = OFFER;
                end
            end
            OFFER: begin
                out_valid = 1'b1;
                out_data  = rb_q;
                out_idx   = idx;
                if (out_ready) begin
                    if (mode) begin
                        state_nx = WAIT_RES;
                    end else begin
                        rb_en = 1'b1;
                        if (last_idx) begin
                            state_nx = DONE;
                        end else begin
                            idx_nx   = idx + IW'(1);
                            state_nx = OFFER;
                        end
                    end
                end
            end
            WAIT_RES: begin
                if (res_valid) begin
                    rb_en   = 1'b1;
                    rb_wren = 1'b1;
                    rb_d    = res_data;
                    if (last_idx) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx   = idx + IW'(1);
                        state_nx = OFFER;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ringbuf_pass_ctrl.sv
// Randomized scoreboard bench for ringbuf_pass_ctrl driving a behavioural
// ring buffer preloaded with 10,20,30,40.
module tb_ringbuf_pass_ctrl;

    localparam int NB = 8;
    localparam int NW = 4;
    localparam int IW = $clog2(NW);

    typedef struct packed {
        logic [NB-1:0] data;
        logic [IW-1:0] idx;
    } offer_t;

    logic          clk = 1'b0;
    logic          rstb;
    logic          start;
    logic          mode_wr;
    logic          busy;
    logic          done;
    logic          rb_en;
    logic          rb_wren;
    logic [NB-1:0] rb_d;
    logic [NB-1:0] rb_q;
    logic [NB-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] res_data;
    logic          res_valid;

    int            checks        = 0;
    int            passed        = 0;
    int            done_count    = 0;
    int            expected_done = 0;
    offer_t        exp_q[$];
    logic [NB-1:0] ref_vals[NW];
    logic [NB-1:0] rb_mem[NW];
    int            rb_head;
    logic          rb_reload;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    ringbuf_pass_ctrl #(
        .nbits (NB),
        .nwords(NW)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .start    (start),
        .mode_wr  (mode_wr),
        .busy     (busy),
        .done     (done),
        .rb_en    (rb_en),
        .rb_wren  (rb_wren),
        .rb_d     (rb_d),
        .rb_q     (rb_q),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res_data (res_data),
        .res_valid(res_valid)
    );

    // Attached ring buffer: head word visible on q, en rotates, wren replaces head.
    assign rb_q = rb_mem[rb_head];

    always @(posedge clk) begin
        if (rb_reload) begin
            for (int i = 0; i < NW; i++) rb_mem[i] <= NB'((i + 1) * 10);
            rb_head <= 0;
        end else if (rb_en) begin
            if (rb_wren) rb_mem[rb_head] <= rb_d;
            rb_head <= (rb_head + 1) % NW;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Monitor: pops the scoreboard on every accepted offer and checks pass-level rules.
    logic          prev_stall = 1'b0;
    logic [NB-1:0] prev_data  = '0;
    logic [IW-1:0] prev_idx   = '0;
    int            en_count   = 0;

    always @(negedge clk) begin
        offer_t e;
        if (rb_reload) begin
            en_count   = 0;
            prev_stall = 1'b0;
        end else if (mon_en) begin
            if (rb_en) en_count++;
            if (!rb_wren) checkOutput("rb_d_zero_without_wren", 32'(rb_d), 0);
            if (prev_stall) begin
                checkOutput("stall_valid_held", 32'(out_valid), 1);
                checkOutput("stall_data_held", 32'(out_data), 32'(prev_data));
                checkOutput("stall_idx_held", 32'(out_idx), 32'(prev_idx));
            end
            if (out_valid && !out_ready) checkOutput("no_advance_on_stall", 32'(rb_en), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_offer: got data %0d idx %0d, expected no offer",
                             out_data, out_idx);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("offer_data", 32'(out_data), 32'(e.data));
                    checkOutput("offer_idx", 32'(out_idx), 32'(e.idx));
                end
            end
            if (done) begin
                done_count++;
                checkOutput("advances_per_pass", 32'(en_count), NW);
                checkOutput("head_restored", 32'(rb_q), 32'(ref_vals[0]));
                en_count = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end
    end

    // One full pass: expectations are queued from the model, then the DUT is driven
    // with random ready, spurious start/res_valid and a delayed write-back responder.
    task automatic applyStimulus(input bit wr, input int ready_pct, input logic [NB-1:0] delta,
                                 input int stall_idx, input bit start_in_done, output int cycles);
        logic [NB-1:0] last_offer = '0;
        int            stalls     = 0;
        bit            finished   = 1'b0;
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back('{data: ref_vals[i], idx: IW'(i)});
            if (wr) ref_vals[i] = ref_vals[i] + delta;
        end
        expected_done++;
        mode_wr = wr;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        mode_wr = 1'($urandom_range(1));
        cycles  = 1;
        while (cycles < 200) begin
            if (done) begin
                finished = 1'b1;
                break;
            end
            out_ready = 1'b0;
            res_valid = 1'b0;
            res_data  = NB'($urandom);
            start     = ($urandom_range(3) == 0);
            if (out_valid) begin
                last_offer = out_data;
                res_valid  = 1'($urandom_range(1));
                if (int'(out_idx) == stall_idx && stalls < 3) stalls++;
                else out_ready = ($urandom_range(99) < ready_pct);
            end else if (busy) begin
                res_valid = 1'($urandom_range(1));
                res_data  = last_offer + delta;
            end
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("pass_finished", 32'(finished), 1);
        start     = start_in_done;
        out_ready = 1'b0;
        res_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("done_single_cycle", 32'(done), 0);
        checkOutput("idle_after_done", 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        rstb      = 1'b0;
        start     = 1'b0;
        mode_wr   = 1'b0;
        out_ready = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        rb_reload = 1'b1;
        for (int i = 0; i < NW; i++) ref_vals[i] = NB'((i + 1) * 10);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    32'({busy, done, rb_en, rb_wren, rb_d, out_data, out_idx, out_valid}), 0);
        rb_reload = 1'b0;
        rstb      = 1'b1;
        mon_en    = 1'b1;

        // res_valid while idle must not touch the ring
        res_valid = 1'b1;
        res_data  = 8'hA5;
        #1;
        checkOutput("idle_res_valid_no_en", 32'(rb_en), 0);
        @(posedge clk); #1;
        res_valid = 1'b0;
        checkOutput("idle_res_valid_stays_idle", 32'(busy), 0);

        // read-only pass at full rate: done five clocks after start
        applyStimulus(1'b0, 100, 8'd0, -1, 1'b0, cyc);
        checkOutput("read_latency", 32'(cyc), 5);

        // write pass adding 1, then a read pass sees 11,21,31,41
        applyStimulus(1'b1, 100, 8'd1, -1, 1'b0, cyc);
        applyStimulus(1'b0, 100, 8'd0, -1, 1'b0, cyc);

        // backpressure on idx 2
        applyStimulus(1'b0, 100, 8'd0, 2, 1'b0, cyc);

        // start during DONE ignored, then back-to-back pass
        applyStimulus(1'b1, 70, 8'd5, 1, 1'b1, cyc);
        applyStimulus(1'b0, 80, 8'd0, -1, 1'b0, cyc);

        // reset while waiting for the idx 1 result
        exp_q.push_back('{data: ref_vals[0], idx: IW'(0)});
        exp_q.push_back('{data: ref_vals[1], idx: IW'(1)});
        mode_wr   = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        res_valid = 1'b1;
        res_data  = ref_vals[0] + 8'd1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("in_wait_res_before_reset", 32'({busy, out_valid}), 32'(2'b10));
        rstb      = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("outputs_after_midpass_reset",
                    32'({busy, done, rb_en, rb_wren, rb_d, out_data, out_idx, out_valid}), 0);
        checkOutput("aborted_pass_offers", 32'(exp_q.size()), 0);
        rstb      = 1'b1;
        rb_reload = 1'b1;
        for (int i = 0; i < NW; i++) ref_vals[i] = NB'((i + 1) * 10);
        @(posedge clk); #1;
        rb_reload = 1'b0;
        checkOutput("no_done_after_reset", 32'(done_count), 32'(expected_done));

        // randomized passes
        for (int p = 0; p < 12; p++) begin
            applyStimulus(1'($urandom_range(1)), 30 + int'($urandom_range(70)),
                          NB'($urandom), int'($urandom_range(NW)), 1'($urandom_range(1)), cyc);
        end

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);
        checkOutput("done_count", 32'(done_count), 32'(expected_done));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
